fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core. It sits directly upstream of decode and the hazard unit. It holds the PC and drives a variable-latency instruction-memory handshake. It absorbs decode stalls and taken-branch redirects from decode, and inserts bubbles into decode whenever no valid instruction is available.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stallD  in  1  from hazard unit; IF/ID must hold.
- pcsrcD  in  1  branch/jump in decode is taken.
- pcbranchD  in  32  redirect target; bits [1:0] ignored and forced to 00.
- imem_req  out  1  fetch request; level signal.
- imem_addr  out  32  fetch address; stable while imem_req=1 until imem_ready.
- imem_ready  in  1  one-cycle completion strobe; may be asserted in the same cycle as the request (zero wait).
- imem_rdata  in  32  instruction; valid only when imem_ready=1.
- instrD  out  32  IF/ID instruction.
- pcplus4D  out  32  IF/ID PC+4.
- validD  out  1  IF/ID holds a real instruction; when 0, instrD is 0 (nop).
- pcF  out  32  current fetch PC, for debug.

## Operation
- Definitions: redir = pcsrcD & !stallD. "Load bubble" means instrD←0, pcplus4D←0, validD←0.
- The IF/ID register changes only when stallD=0, or on reset.

FSM states and transitions:
- **FETCH**: imem_req=1, imem_addr=pcF.
  - redir: pcF←pcbranchD; load bubble. If imem_ready=1, stay in FETCH. Otherwise dropaddr←pcF and go to DROP.
  - imem_ready & !stallD: instrD←imem_rdata, pcplus4D←pcF+4, validD←1; pcF←pcF+4; stay in FETCH.
  - imem_ready & stallD: buf←imem_rdata; go to HOLD; pcF unchanged.
  - !imem_ready & !stallD: load bubble.
- **HOLD**: imem_req=0.
  - redir: pcF←pcbranchD; load bubble; discard buf; go to FETCH.
  - !stallD: instrD←buf, pcplus4D←pcF+4, validD←1; pcF←pcF+4; go to FETCH.
  - Otherwise stay in HOLD.
- **DROP**: imem_req=1, imem_addr=dropaddr. The response to an abandoned request is awaited and discarded.
  - redir: pcF←pcbranchD (latest redirect wins); load bubble.
  - imem_ready: discard imem_rdata; go to FETCH. If !stallD and no redir, load bubble.
  - !imem_ready: stay in DROP; load bubble if !stallD.

Arithmetic:
- PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Reset (asynchronous):
- state=FETCH, pcF=RESET_PC, instrD=0, pcplus4D=0, validD=0, buf=0, dropaddr=0.
- imem_req is forced to 0 while reset=1.

## Timing
- Zero-wait memory, no stalls: throughput is one instruction per cycle. An instruction returned in cycle n is visible on instrD in cycle n+1.
- Wait-state memory: one bubble reaches decode per unstalled wait cycle.
- redir takes priority over imem_ready and over buf contents.
- The wrong-path instruction never reaches decode. A taken branch costs exactly one bubble under zero-wait memory.
- Reset asserted mid-DROP: the outstanding response is not tracked. The memory model must also reset.

## Structure
- Shared package/defines: FSM state encodings (FETCH=2'd0, HOLD=2'd1, DROP=2'd2) and NOP_INSTR=32'h0.
- One natural sub-module, **fetch_ifid_reg**: the IF/ID register with enable (!stallD), bubble-load, and asynchronous reset.
- The PC register, FSM, buf, and dropaddr stay in fetch_unit.

## Test plan
- Zero-wait memory, reset deasserted, RESET_PC=0: instrD sequence is mem[0], mem[4], mem[8] on consecutive cycles with validD=1; pcF=0x0C after 3 cycles.
- 2-wait-state memory: validD pattern is 0,0,1 repeating; pcplus4D values are 4, 8, 12.
- Ready while stallD=1 for 3 cycles: state is HOLD, imem_req=0. After stallD drops, instrD=buf, and the next address requested is pcF+4.
- pcsrcD=1, pcbranchD=0x40 with zero-wait memory: one bubble (validD=0), then instrD=mem[0x40] with pcplus4D=0x44.
- Redirect to 0x80 while the request for 0x10 is waiting: imem_addr stays 0x10 until ready, and that data is never seen on instrD. The next request is 0x80.
- Reset asserted asynchronously mid-HOLD: outputs go to 0 immediately, without waiting for a clock edge. After release, the first request is to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, the nop word
// and the IF/ID payload layout.
package fetch_unit_pkg;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};

    // Redirect targets are always word addresses; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // PC+4 wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response handshake between the fetch unit and imem.
interface fetch_unit_if #(
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: holds while disabled, otherwise loads either a real
// instruction or a bubble (all-zero payload).
module fetch_ifid_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);

    ifid_t r_ifid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ifid <= IFID_BUBBLE;
        end else if (i_en) begin
            if (i_valid) begin
                r_ifid.instr   <= i_instr;
                r_ifid.pcplus4 <= i_pcplus4;
                r_ifid.valid   <= 1'b1;
            end else begin
                r_ifid <= IFID_BUBBLE;
            end
        end
    end

    assign o_instr   = r_ifid.instr;
    assign o_pcplus4 = r_ifid.pcplus4;
    assign o_valid   = r_ifid.valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, variable-latency imem handshake FSM and IF/ID register.
// Requests abandoned by a redirect are drained in DROP so stale data never reaches decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stallD,
    input  logic         pcsrcD,
    input  logic [31:0]  pcbranchD,
    fetch_unit_if.master imem,
    output logic [31:0]  instrD,
    output logic [31:0]  pcplus4D,
    output logic         validD,
    output logic [31:0]  pcF
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_dropaddr;

    logic        w_redir;
    logic [31:0] w_target;
    logic [31:0] w_pcplus4;
    logic        w_ld_valid;
    logic [31:0] w_ld_instr;
    logic [31:0] w_ld_pcplus4;

    assign w_redir   = pcsrcD & ~stallD;
    assign w_target  = word_align(pcbranchD);
    assign w_pcplus4 = pc_inc(r_pc);

    // Request is a level; reset gates it combinationally so memory sees it drop at once.
    assign imem.imem_req  = ~reset & ((r_state == ST_FETCH) | (r_state == ST_DROP));
    assign imem.imem_addr = (r_state == ST_DROP) ? r_dropaddr : r_pc;

    // Payload offered to IF/ID; anything not marked valid is loaded as a bubble.
    always_comb begin
        w_ld_valid   = 1'b0;
        w_ld_instr   = NOP_INSTR;
        w_ld_pcplus4 = 32'h0;
        case (r_state)
            ST_FETCH: begin
                if (!w_redir && imem.imem_ready) begin
                    w_ld_valid   = 1'b1;
                    w_ld_instr   = imem.imem_rdata;
                    w_ld_pcplus4 = w_pcplus4;
                end
            end
            ST_HOLD: begin
                if (!w_redir) begin
                    w_ld_valid   = 1'b1;
                    w_ld_instr   = r_buf;
                    w_ld_pcplus4 = w_pcplus4;
                end
            end
            default: begin
                w_ld_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_buf      <= NOP_INSTR;
            r_dropaddr <= 32'h0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_redir) begin
                        r_pc <= w_target;
                        if (!imem.imem_ready) begin
                            r_dropaddr <= r_pc;
                            r_state    <= ST_DROP;
                        end
                    end else if (imem.imem_ready) begin
                        if (!stallD) begin
                            r_pc <= w_pcplus4;
                        end else begin
                            r_buf   <= imem.imem_rdata;
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_redir) begin
                        r_pc    <= w_target;
                        r_buf   <= NOP_INSTR;
                        r_state <= ST_FETCH;
                    end else if (!stallD) begin
                        r_pc    <= w_pcplus4;
                        r_state <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    // The latest redirect wins; the drained response is simply ignored.
                    if (w_redir) begin
                        r_pc <= w_target;
                    end
                    if (imem.imem_ready) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    fetch_ifid_reg u_ifid (
        .clk       (clk),
        .reset     (reset),
        .i_en      (~stallD),
        .i_valid   (w_ld_valid),
        .i_instr   (w_ld_instr),
        .i_pcplus4 (w_ld_pcplus4),
        .o_instr   (instrD),
        .o_pcplus4 (pcplus4D),
        .o_valid   (validD)
    );

    assign pcF = r_pc;

endmodule
